// File: rtl/fifo_ctrl_param_if.sv
// Handshake and status bundle for fifo_ctrl_param.
// The master side drives the requests. The slave side (the FIFO) drives data and status back.
interface fifo_ctrl_param_if #(
  parameter int DATA_W = 16,
  parameter int PTR_W  = 2
);
  logic              push_fifo;
  logic              pop_fifo;
  logic              flush;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              fifo_empty;
  logic              fifo_full;
  logic              almost_full;
  logic              almost_empty;
  logic [PTR_W:0]    count;
  logic [PTR_W-1:0]  curr_head;
  logic [PTR_W-1:0]  curr_tail;
  logic              overflow;
  logic              underflow;

  modport master (
    output push_fifo, pop_fifo, flush, data_in,
    input  data_out, fifo_empty, fifo_full, almost_full, almost_empty,
    input  count, curr_head, curr_tail, overflow, underflow
  );

  modport slave (
    input  push_fifo, pop_fifo, flush, data_in,
    output data_out, fifo_empty, fifo_full, almost_full, almost_empty,
    output count, curr_head, curr_tail, overflow, underflow
  );
endinterface

// File: rtl/fifo_ctrl_param.sv
// Parametrised synchronous FIFO: storage, head/tail pointers, occupancy count,
// threshold flags, flush, and registered overflow/underflow pulses.

// Basic enable flop with optional synchronous reset; holds all FIFO state.
module fifo_ctrl_dff #(
  parameter int           W       = 1,
  parameter bit           RST_EN  = 1'b1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // Reset, when enabled, takes priority over the load enable.
  always_ff @(posedge clk) begin
    if (RST_EN && rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end
endmodule

module fifo_ctrl_param #(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 4,
  parameter int PTR_W     = 2,
  parameter int AFULL_TH  = DEPTH - 1,
  parameter int AEMPTY_TH = 1
) (
  input  logic               clk,
  input  logic               rst,
  fifo_ctrl_param_if.slave   bus
);
  localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   AFULL_C  = (PTR_W+1)'(AFULL_TH);
  localparam logic [PTR_W:0]   AEMPTY_C = (PTR_W+1)'(AEMPTY_TH);
  localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   CNT_ZERO = {(PTR_W+1){1'b0}};

  logic [PTR_W-1:0]  head_r, tail_r;
  logic [PTR_W:0]    count_r;
  logic              ovf_r, udf_r;
  logic [PTR_W-1:0]  head_nxt_s, tail_nxt_s;
  logic [PTR_W:0]    count_nxt_s;
  logic              ovf_nxt_s, udf_nxt_s;
  logic              empty_s, full_s;
  logic              pop_ok_s, push_ok_s, mem_we_s;
  logic [DEPTH-1:0]  wr_en_s;
  logic [DATA_W-1:0] mem_q_s [DEPTH];

  assign empty_s   = (count_r == CNT_ZERO);
  assign full_s    = (count_r == DEPTH_C);
  // A pop on a full FIFO frees the slot that a simultaneous push needs.
  assign pop_ok_s  = bus.pop_fifo & ~empty_s;
  assign push_ok_s = bus.push_fifo & (~full_s | pop_ok_s);
  assign mem_we_s  = push_ok_s & ~bus.flush;

  // Next-state pointer, count and error-pulse computation.
  always_comb begin
    head_nxt_s  = head_r;
    tail_nxt_s  = tail_r;
    count_nxt_s = count_r;
    ovf_nxt_s   = 1'b0;
    udf_nxt_s   = 1'b0;
    if (bus.flush) begin
      head_nxt_s  = {PTR_W{1'b0}};
      tail_nxt_s  = {PTR_W{1'b0}};
      count_nxt_s = CNT_ZERO;
    end else begin
      if (pop_ok_s) begin
        head_nxt_s = head_r + PTR_ONE;
      end else begin
        head_nxt_s = head_r;
      end
      if (push_ok_s) begin
        tail_nxt_s = tail_r + PTR_ONE;
      end else begin
        tail_nxt_s = tail_r;
      end
      count_nxt_s = count_r + {{PTR_W{1'b0}}, push_ok_s} - {{PTR_W{1'b0}}, pop_ok_s};
      ovf_nxt_s   = bus.push_fifo & ~push_ok_s;
      udf_nxt_s   = bus.pop_fifo & ~pop_ok_s;
    end
  end

  fifo_ctrl_dff #(.W(PTR_W)) u_head (
    .clk(clk), .rst(rst), .en(1'b1), .d(head_nxt_s), .q(head_r)
  );
  fifo_ctrl_dff #(.W(PTR_W)) u_tail (
    .clk(clk), .rst(rst), .en(1'b1), .d(tail_nxt_s), .q(tail_r)
  );
  fifo_ctrl_dff #(.W(PTR_W+1)) u_count (
    .clk(clk), .rst(rst), .en(1'b1), .d(count_nxt_s), .q(count_r)
  );
  fifo_ctrl_dff #(.W(1)) u_ovf (
    .clk(clk), .rst(rst), .en(1'b1), .d(ovf_nxt_s), .q(ovf_r)
  );
  fifo_ctrl_dff #(.W(1)) u_udf (
    .clk(clk), .rst(rst), .en(1'b1), .d(udf_nxt_s), .q(udf_r)
  );

  // Storage entries are not reset; the empty decode masks stale contents.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
    assign wr_en_s[gi] = mem_we_s & (tail_r == PTR_W'(gi));
    fifo_ctrl_dff #(.W(DATA_W), .RST_EN(1'b0)) u_entry (
      .clk(clk), .rst(rst), .en(wr_en_s[gi]), .d(bus.data_in), .q(mem_q_s[gi])
    );
  end

  assign bus.data_out     = empty_s ? {DATA_W{1'b0}} : mem_q_s[head_r];
  assign bus.fifo_empty   = empty_s;
  assign bus.fifo_full    = full_s;
  assign bus.almost_full  = (count_r >= AFULL_C);
  assign bus.almost_empty = (count_r <= AEMPTY_C);
  assign bus.count        = count_r;
  assign bus.curr_head    = head_r;
  assign bus.curr_tail    = tail_r;
  assign bus.overflow     = ovf_r;
  assign bus.underflow    = udf_r;
endmodule

// File: tb/tb_fifo_ctrl_param.sv
// Self-checking bench for fifo_ctrl_param (DEPTH=4, DATA_W=16): directed scenarios
// plus randomized traffic against a queue-based reference model.
module tb_fifo_ctrl_param;
  localparam int DW = 16;
  localparam int DEPTH = 4;
  localparam int PW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [DW-1:0] m_q[$];
  int            m_head = 0;
  int            m_tail = 0;
  bit            m_ovf  = 1'b0;
  bit            m_udf  = 1'b0;

  fifo_ctrl_param_if #(.DATA_W(DW), .PTR_W(PW)) bus ();

  fifo_ctrl_param #(.DATA_W(DW), .DEPTH(DEPTH), .PTR_W(PW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs, advance the model, then sample 1 time unit past the edge.
  task automatic drive(input bit r, input bit p, input bit q, input bit f, input logic [DW-1:0] d);
    bit pop_ok, push_ok;
    rst = r;
    bus.push_fifo = p;
    bus.pop_fifo = q;
    bus.flush = f;
    bus.data_in = d;
    if (r || f) begin
      m_q.delete();
      m_head = 0; m_tail = 0; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      pop_ok  = q && (m_q.size() > 0);
      push_ok = p && ((m_q.size() < DEPTH) || pop_ok);
      if (pop_ok) begin
        void'(m_q.pop_front());
        m_head = (m_head + 1) % DEPTH;
      end
      if (push_ok) begin
        m_q.push_back(d);
        m_tail = (m_tail + 1) % DEPTH;
      end
      m_ovf = p && !push_ok;
      m_udf = q && !pop_ok;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    n_tests++; if (bus.fifo_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty act=%b exp=1", bus.fifo_empty); end
    n_tests++; if (bus.almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_aempty act=%b exp=1", bus.almost_empty); end
    n_tests++; if (bus.fifo_full !== 1'b0 || bus.almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_full act=%b%b exp=00", bus.fifo_full, bus.almost_full); end
    n_tests++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL reset_count act=%0d exp=0", bus.count); end
    n_tests++; if (bus.data_out !== 16'h0000) begin n_fail++; $display("FAIL reset_data act=%h exp=0000", bus.data_out); end
    n_tests++; if (bus.curr_head !== 2'd0 || bus.curr_tail !== 2'd0) begin n_fail++; $display("FAIL reset_ptrs act=%0d/%0d exp=0/0", bus.curr_head, bus.curr_tail); end
  endtask

  task automatic test_fill_overflow();
    logic [DW-1:0] vals [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, vals[i]);
    n_tests++; if (bus.fifo_full !== 1'b1 || bus.almost_full !== 1'b1) begin n_fail++; $display("FAIL fill_full act=%b%b exp=11", bus.fifo_full, bus.almost_full); end
    n_tests++; if (bus.count !== 3'd4) begin n_fail++; $display("FAIL fill_count act=%0d exp=4", bus.count); end
    n_tests++; if (bus.curr_tail !== 2'd0) begin n_fail++; $display("FAIL fill_tail_wrap act=%0d exp=0", bus.curr_tail); end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h5555);
    n_tests++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse act=%b exp=1", bus.overflow); end
    n_tests++; if (bus.count !== 3'd4 || bus.data_out !== 16'h1111) begin n_fail++; $display("FAIL ovf_hold act=%0d/%h exp=4/1111", bus.count, bus.data_out); end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    n_tests++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear act=%b exp=0", bus.overflow); end
  endtask

  task automatic test_drain_underflow();
    logic [DW-1:0] vals [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (bus.data_out !== vals[i]) begin n_fail++; $display("FAIL drain_order[%0d] act=%h exp=%h", i, bus.data_out, vals[i]); end
      drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    end
    n_tests++; if (bus.fifo_empty !== 1'b1 || bus.curr_head !== 2'd0) begin n_fail++; $display("FAIL drain_empty act=%b/%0d exp=1/0", bus.fifo_empty, bus.curr_head); end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    n_tests++; if (bus.underflow !== 1'b1 || bus.count !== 3'd0) begin n_fail++; $display("FAIL udf_pulse act=%b/%0d exp=1/0", bus.underflow, bus.count); end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    n_tests++; if (bus.underflow !== 1'b0) begin n_fail++; $display("FAIL udf_clear act=%b exp=0", bus.underflow); end
  endtask

  task automatic test_full_push_pop();
    logic [DW-1:0] fill [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    logic [DW-1:0] exp  [4] = '{16'h2222, 16'h3333, 16'h4444, 16'hAAAA};
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, fill[i]);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'hAAAA);
    n_tests++; if (bus.count !== 3'd4 || bus.overflow !== 1'b0) begin n_fail++; $display("FAIL fullpp_count act=%0d/%b exp=4/0", bus.count, bus.overflow); end
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (bus.data_out !== exp[i]) begin n_fail++; $display("FAIL fullpp_order[%0d] act=%h exp=%h", i, bus.data_out, exp[i]); end
      drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    end
  endtask

  task automatic test_empty_push_pop();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'hBEEF);
    n_tests++; if (bus.underflow !== 1'b1) begin n_fail++; $display("FAIL emptypp_udf act=%b exp=1", bus.underflow); end
    n_tests++; if (bus.count !== 3'd1 || bus.data_out !== 16'hBEEF) begin n_fail++; $display("FAIL emptypp_data act=%0d/%h exp=1/beef", bus.count, bus.data_out); end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
  endtask

  task automatic test_flush_reset();
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0100 + 16'(i));
    n_tests++; if (bus.count !== 3'd3) begin n_fail++; $display("FAIL flush_pre act=%0d exp=3", bus.count); end
    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h7777);
    n_tests++; if (bus.count !== 3'd0 || bus.fifo_empty !== 1'b1 || bus.overflow !== 1'b0) begin n_fail++; $display("FAIL flush_clear act=%0d/%b/%b exp=0/1/0", bus.count, bus.fifo_empty, bus.overflow); end
    n_tests++; if (bus.curr_head !== 2'd0 || bus.curr_tail !== 2'd0 || bus.data_out !== 16'h0000) begin n_fail++; $display("FAIL flush_ptrs act=%0d/%0d/%h exp=0/0/0000", bus.curr_head, bus.curr_tail, bus.data_out); end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0A0A);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0B0B);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 16'h0C0C);
    n_tests++; if (bus.count !== 3'd0 || bus.curr_head !== 2'd0 || bus.curr_tail !== 2'd0) begin n_fail++; $display("FAIL rst_mid act=%0d/%0d/%0d exp=0/0/0", bus.count, bus.curr_head, bus.curr_tail); end
    n_tests++; if (bus.underflow !== 1'b0 || bus.overflow !== 1'b0 || bus.data_out !== 16'h0000) begin n_fail++; $display("FAIL rst_mid_flags act=%b/%b/%h exp=0/0/0000", bus.underflow, bus.overflow, bus.data_out); end
  endtask

  task automatic test_random();
    logic [28:0] got, exp;
    logic [DW-1:0] e_data;
    int sz, pbias;
    for (int n = 0; n < 800; n++) begin
      pbias = ((n / 40) % 2 == 0) ? 75 : 25;
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 99) < pbias,
            $urandom_range(0, 99) >= pbias, $urandom_range(0, 79) == 0, 16'($urandom));
      sz = m_q.size();
      e_data = (sz > 0) ? m_q[0] : 16'h0000;
      exp = {3'(sz), sz == 0, sz == DEPTH, sz >= DEPTH - 1, sz <= 1,
             2'(m_head), 2'(m_tail), m_ovf, m_udf, e_data};
      got = {bus.count, bus.fifo_empty, bus.fifo_full, bus.almost_full, bus.almost_empty,
             bus.curr_head, bus.curr_tail, bus.overflow, bus.underflow, bus.data_out};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL random[%0d] act=%h exp=%h", n, got, exp);
      end
    end
  endtask

  initial begin
    bus.push_fifo = 1'b0;
    bus.pop_fifo  = 1'b0;
    bus.flush     = 1'b0;
    bus.data_in   = 16'h0000;
    test_reset();
    test_fill_overflow();
    test_drain_underflow();
    test_full_push_pop();
    test_empty_push_pop();
    test_flush_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
